// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FPU adder, multiplier and divider.
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] mantissa;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;
endpackage

// File: rtl/fp32_classify.sv
// Splits a binary32 operand into class, sign, exponent and mantissa with hidden bit.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]      operand,
  output fp_class_e        op_class,
  output logic             sign,
  output logic [EXP_W-1:0] exponent,
  output logic [MAN_W:0]   mantissa
);
  fp32_t fields;
  assign fields = operand;

  assign sign     = fields.sign;
  assign exponent = fields.exponent;
  // Denormals lose their fraction here, so they behave exactly like zero downstream.
  assign mantissa = (fields.exponent == '0) ? '0 : {1'b1, fields.mantissa};

  always_comb begin
    op_class = NORMAL;
    if (fields.exponent == '0)
      op_class = ZERO;
    else if (fields.exponent == '1)
      op_class = (fields.mantissa == '0) ? INF : NAN;
  end
endmodule

// File: rtl/fpu_division.sv
// Free-running iterative binary32 divider: capture, 26 restoring steps, round,
// then publish o with a one-cycle finish pulse every 28 cycles.
module fpu_division
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] o,
  output logic        finish
);
  typedef enum logic [1:0] {S_CAPTURE, S_DIVIDE, S_ROUND} state_e;

  localparam logic [4:0] LAST_STEP = 5'd25;

  fp_class_e        a_class, b_class;
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_man, b_man;

  fp32_classify u_class_a (
    .operand  (a),
    .op_class (a_class),
    .sign     (a_sign),
    .exponent (a_exp),
    .mantissa (a_man)
  );

  fp32_classify u_class_b (
    .operand  (b),
    .op_class (b_class),
    .sign     (b_sign),
    .exponent (b_exp),
    .mantissa (b_man)
  );

  state_e             state_reg;
  logic [4:0]         step_reg;
  logic               sign_reg;
  logic signed [9:0]  exp_reg;
  logic [24:0]        rem_reg;
  logic [MAN_W:0]     mb_reg;
  logic [25:0]        quo_reg;
  logic               special_reg;
  logic [31:0]        special_val_reg;
  logic [31:0]        o_reg;
  logic               finish_reg;

  logic               sign_next;
  logic signed [9:0]  exp_next;
  logic               special_next;
  logic [31:0]        special_val_next;

  assign sign_next = a_sign ^ b_sign;
  assign exp_next  = {2'b00, a_exp} - {2'b00, b_exp} + 10'(BIAS);

  // Special operands are decided at capture; the divide still runs so latency stays fixed.
  always_comb begin
    special_next     = 1'b1;
    special_val_next = '0;
    if (a_class == NAN || b_class == NAN ||
        (a_class == ZERO && b_class == ZERO) ||
        (a_class == INF && b_class == INF))
      special_val_next = QNAN;
    else if (b_class == ZERO || a_class == INF)
      special_val_next = {sign_next, POS_INF[30:0]};
    else if (b_class == INF || a_class == ZERO)
      special_val_next = {sign_next, 31'h0};
    else
      special_next = 1'b0;
  end

  logic               rem_ge;
  logic [24:0]        rem_sub;
  assign rem_ge  = (rem_reg >= {1'b0, mb_reg});
  assign rem_sub = rem_ge ? (rem_reg - {1'b0, mb_reg}) : rem_reg;

  logic [23:0]        mant_norm;
  logic               guard_bit, sticky_bit, round_up;
  logic signed [9:0]  exp_norm, exp_fin;
  logic [24:0]        mant_sum;
  logic [MAN_W-1:0]   frac_fin;
  logic [31:0]        result;

  always_comb begin
    if (quo_reg[25]) begin
      mant_norm  = quo_reg[25:2];
      guard_bit  = quo_reg[1];
      sticky_bit = quo_reg[0] | (rem_reg != '0);
      exp_norm   = exp_reg;
    end else begin
      mant_norm  = quo_reg[24:1];
      guard_bit  = quo_reg[0];
      sticky_bit = (rem_reg != '0);
      exp_norm   = exp_reg - 10'sd1;
    end
    round_up = guard_bit & (sticky_bit | mant_norm[0]);
    mant_sum = {1'b0, mant_norm} + {24'h0, round_up};
    // A carry out of rounding leaves 1.000..., so only the exponent moves.
    frac_fin = mant_sum[24] ? mant_sum[23:1] : mant_sum[22:0];
    exp_fin  = mant_sum[24] ? (exp_norm + 10'sd1) : exp_norm;

    if (special_reg)
      result = special_val_reg;
    else if (exp_fin >= 10'sd255)
      result = {sign_reg, POS_INF[30:0]};
    else if (exp_fin <= 10'sd0)
      result = {sign_reg, 31'h0};
    else
      result = {sign_reg, exp_fin[7:0], frac_fin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_CAPTURE;
      step_reg        <= '0;
      sign_reg        <= 1'b0;
      exp_reg         <= '0;
      rem_reg         <= '0;
      mb_reg          <= '0;
      quo_reg         <= '0;
      special_reg     <= 1'b0;
      special_val_reg <= '0;
      o_reg           <= '0;
      finish_reg      <= 1'b0;
    end else begin
      finish_reg <= 1'b0;
      case (state_reg)
        S_CAPTURE: begin
          sign_reg        <= sign_next;
          exp_reg         <= exp_next;
          rem_reg         <= {1'b0, a_man};
          mb_reg          <= b_man;
          quo_reg         <= '0;
          special_reg     <= special_next;
          special_val_reg <= special_val_next;
          step_reg        <= '0;
          state_reg       <= S_DIVIDE;
        end
        S_DIVIDE: begin
          quo_reg  <= {quo_reg[24:0], rem_ge};
          rem_reg  <= {rem_sub[23:0], 1'b0};
          step_reg <= step_reg + 5'd1;
          if (step_reg == LAST_STEP)
            state_reg <= S_ROUND;
        end
        S_ROUND: begin
          o_reg      <= result;
          finish_reg <= 1'b1;
          state_reg  <= S_CAPTURE;
        end
        default: state_reg <= S_CAPTURE;
      endcase
    end
  end

  assign o      = o_reg;
  assign finish = finish_reg;
endmodule

// File: tb/tb_fpu_division.sv
// Scoreboard bench for fpu_division: directed and random operands against an
// integer-arithmetic reference of correctly rounded binary32 division.
module tb_fpu_division;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [31:0] o;
  logic        finish;

  fpu_division dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .o      (o),
    .finish (finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expect_o;
  } txn_t;

  txn_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  logic [31:0] held_o   = 32'h0;

  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic   s;
    int     ex, ey, e;
    longint num, den, q, r, mant;
    bit     g, st, x_zero, x_inf, x_nan, y_zero, y_inf, y_nan;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    x_zero = (ex == 0);
    x_inf  = (ex == 255) && (x[22:0] == 23'h0);
    x_nan  = (ex == 255) && (x[22:0] != 23'h0);
    y_zero = (ey == 0);
    y_inf  = (ey == 255) && (y[22:0] == 23'h0);
    y_nan  = (ey == 255) && (y[22:0] != 23'h0);
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) return 32'h7FC0_0000;
    if (y_zero || x_inf) return {s, 8'hFF, 23'h0};
    if (y_inf || x_zero) return {s, 31'h0};
    // Exact integer quotient of the significands scaled by 2^25, plus remainder for sticky.
    num = longint'({1'b1, x[22:0]}) << 25;
    den = longint'({1'b1, y[22:0]});
    q   = num / den;
    r   = num % den;
    e   = ex - ey + 127;
    if (q >= 64'd33554432) begin
      mant = q >> 2;
      g    = q[1];
      st   = q[0] || (r != 0);
    end else begin
      mant = q >> 1;
      g    = q[0];
      st   = (r != 0);
      e    = e - 1;
    end
    if (g && (st || mant[0])) mant = mant + 1;
    if (mant == 64'd16777216) begin
      mant = 64'd8388608;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0: v[30:0] = 31'h0;
      1: v[30:0] = {8'hFF, 23'h0};
      2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3: v[30:23] = 8'h00;
      4: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Caller is just past a clock edge and the next edge is a capture edge.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit scramble);
    txn_t t;
    a = av;
    b = bv;
    @(posedge clk);
    t.a = av;
    t.b = bv;
    t.expect_o = ref_div(av, bv);
    exp_q.push_back(t);
    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1;
      if (scramble && i == 8) begin
        a = $urandom;
        b = $urandom;
      end
    end
  endtask

  // Monitor: pops the scoreboard on every finish pulse and checks pulse spacing and o holding.
  always @(negedge clk) begin
    txn_t t;
    if (!rst_n) begin
      edge_cnt = 0;
      held_o   = 32'h0;
    end else begin
      edge_cnt++;
      if (finish || (edge_cnt % 28 == 0)) begin
        checks++;
        if (finish !== (edge_cnt % 28 == 0)) begin
          failures++;
          $display("FAIL finish_timing edge=%0d finish=%b required=%b", edge_cnt, finish, (edge_cnt % 28 == 0));
        end
      end
      if (finish) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result o=%h required=no pulse", o);
        end else begin
          t = exp_q.pop_front();
          if (o !== t.expect_o) begin
            failures++;
            $display("FAIL result a=%h b=%h o=%h required=%h", t.a, t.b, o, t.expect_o);
          end else begin
            $display("ok a=%h b=%h o=%h", t.a, t.b, o);
          end
        end
        held_o = o;
      end else begin
        checks++;
        if (o !== held_o) begin
          failures++;
          $display("FAIL o_hold edge=%0d o=%h required=%h", edge_cnt, o, held_o);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (o !== 32'h0 || finish !== 1'b0) begin
      failures++;
      $display("FAIL %s o=%h finish=%b required o=00000000 finish=0", tag, o, finish);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = 32'h0;
    b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    run_op(32'h40C0_0000, 32'h4000_0000, 1'b0);
    run_op(32'h3F80_0000, 32'h4040_0000, 1'b0);
    run_op(32'hBF80_0000, 32'h4000_0000, 1'b0);
    run_op(32'h4000_0000, 32'h3F80_0000, 1'b0);
    run_op(32'h3F80_0000, 32'h0000_0000, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0);
    run_op(32'h7F80_0000, 32'h7F80_0000, 1'b0);
    run_op(32'h3F80_0000, 32'h7F80_0000, 1'b0);
    run_op(32'h7F00_0000, 32'h3E80_0000, 1'b0);
    run_op(32'h0080_0000, 32'h4000_0000, 1'b0);
    run_op(32'h40C0_0000, 32'h4000_0000, 1'b1);

    // Abort an operation partway through the divide.
    a = 32'h4120_0000;
    b = 32'h4040_0000;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("reset_abort");
    @(negedge clk);
    #1;
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    run_op(32'h4120_0000, 32'h4000_0000, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(rand_operand(), rand_operand(), 1'b1);

    for (int i = 0; i < 30 && exp_q.size() != 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
